// File: rtl/gcd_arbiter_if.sv
// gcd_arbiter_if: request/response channel bundle between requesters, the GCD engine and its consumer.
interface gcd_arbiter_if #(
    parameter int BusSize = 8,
    parameter int NumReq  = 4,
    parameter int MaxIter = 600,
    parameter int IdW     = $clog2(NumReq),
    parameter int IterW   = $clog2(MaxIter + 1)
);
    logic [NumReq-1:0]         req_valid;
    logic [NumReq-1:0]         req_ready;
    logic [NumReq*BusSize-1:0] req_a;
    logic [NumReq*BusSize-1:0] req_b;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [IdW-1:0]            rsp_id;
    logic [BusSize-1:0]        rsp_gcd;
    logic [IterW-1:0]          rsp_iter;
    logic                      rsp_err;
    logic                      busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_gcd, rsp_iter, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_gcd, rsp_iter, rsp_err, busy
    );
endinterface

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin shared subtract-and-swap GCD engine with id-tagged responses.
module gcd_arbiter #(
    parameter int BusSize = 8,
    parameter int NumReq  = 4,
    parameter int MaxIter = 600,
    parameter int IdW     = $clog2(NumReq),
    parameter int IterW   = $clog2(MaxIter + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    gcd_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e             state_q, state_d;
    logic [BusSize-1:0] a_q, a_d, b_q, b_d, gcd_q, gcd_d;
    logic [IterW-1:0]   iter_q, iter_d, rsp_iter_q, rsp_iter_d;
    logic [IdW-1:0]     ptr_q, ptr_d, cur_q, cur_d, id_q, id_d, gidx;
    logic               valid_q, valid_d, err_q, err_d, any;
    logic [NumReq-1:0]  gnt;
    int                 k;

    // Scan downward so the slot closest after the pointer wins last.
    always_comb begin
        gidx = '0;
        k    = 0;
        for (int i = NumReq; i >= 1; i--) begin
            k = (int'(ptr_q) + i) % NumReq;
            if (bus.req_valid[k]) gidx = IdW'(k);
        end
        any = |bus.req_valid;
        gnt = any ? NumReq'(1) << gidx : '0;
    end

    assign bus.req_ready = (state_q == IDLE && rst_ni) ? gnt : '0;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_gcd   = gcd_q;
    assign bus.rsp_iter  = rsp_iter_q;
    assign bus.rsp_err   = err_q;
    assign bus.busy      = state_q != IDLE;

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        iter_d     = iter_q;
        ptr_d      = ptr_q;
        cur_d      = cur_q;
        id_d       = id_q;
        gcd_d      = gcd_q;
        rsp_iter_d = rsp_iter_q;
        err_d      = err_q;
        valid_d    = valid_q;
        case (state_q)
            IDLE: if (any) begin
                a_d     = bus.req_a[gidx*BusSize +: BusSize];
                b_d     = bus.req_b[gidx*BusSize +: BusSize];
                cur_d   = gidx;
                iter_d  = '0;
                state_d = RUN;
            end
            RUN: begin
                if (a_q == '0 || b_q == '0 || a_q == b_q || iter_q == IterW'(MaxIter)) begin
                    // Termination takes priority over the step cap.
                    err_d      = !(a_q == '0 || b_q == '0 || a_q == b_q);
                    gcd_d      = err_d ? '0 : (a_q == '0 ? b_q : a_q);
                    rsp_iter_d = iter_q;
                    id_d       = cur_q;
                    valid_d    = 1'b1;
                    state_d    = DONE;
                end else begin
                    a_d    = a_q > b_q ? a_q - b_q : b_q;
                    b_d    = a_q > b_q ? b_q : a_q;
                    iter_d = iter_q + 1'b1;
                end
            end
            DONE: if (bus.rsp_ready) begin
                valid_d = 1'b0;
                ptr_d   = id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            iter_q     <= '0;
            ptr_q      <= IdW'(NumReq - 1);
            cur_q      <= '0;
            id_q       <= '0;
            gcd_q      <= '0;
            rsp_iter_q <= '0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            iter_q     <= iter_d;
            ptr_q      <= ptr_d;
            cur_q      <= cur_d;
            id_q       <= id_d;
            gcd_q      <= gcd_d;
            rsp_iter_q <= rsp_iter_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
        end
    end
endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter: directed scenario bench for gcd_arbiter, plus a MaxIter=10 instance for the step cap.
module tb_gcd_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    gcd_arbiter_if #(.BusSize(8), .NumReq(4), .MaxIter(600)) bus ();
    gcd_arbiter_if #(.BusSize(8), .NumReq(4), .MaxIter(10))  bus2 ();

    gcd_arbiter #(.BusSize(8), .NumReq(4), .MaxIter(600)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus)
    );
    gcd_arbiter #(.BusSize(8), .NumReq(4), .MaxIter(10)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus2)
    );

    // Present a request at a negedge, return the ready seen before the accept edge and edges-to-valid after it.
    task automatic do_op(input int r, input logic [7:0] a, input logic [7:0] b,
                         output logic [3:0] rdy, output int n);
        bus.req_valid[r] = 1'b1;
        bus.req_a[r*8 +: 8] = a;
        bus.req_b[r*8 +: 8] = b;
        #1 rdy = bus.req_ready;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid[r] = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 2000) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            failures++;
            $display("FAIL timeout waiting rsp_valid req=%0d", r);
        end
    endtask

    task automatic ack();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 4'b1111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.rsp_valid); end
        checks++; if (bus.rsp_gcd !== 8'd0 || bus.rsp_iter !== 10'd0 || bus.rsp_id !== 2'd0 || bus.rsp_err !== 1'b0)
            begin failures++; $display("FAIL reset_rsp got gcd=%0d iter=%0d id=%0d err=%b exp all 0", bus.rsp_gcd, bus.rsp_iter, bus.rsp_id, bus.rsp_err); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        bus.req_valid = 4'b0000;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [3:0] rdy;
        int n;
        do_op(0, 8'd12, 8'd8, rdy, n);
        checks++; if (rdy !== 4'b0001) begin failures++; $display("FAIL basic_ready got=%b exp=0001", rdy); end
        checks++; if (n !== 4) begin failures++; $display("FAIL basic_latency got=%0d exp=4", n); end
        checks++; if (bus.rsp_gcd !== 8'd4 || bus.rsp_iter !== 10'd3 || bus.rsp_id !== 2'd0 || bus.rsp_err !== 1'b0)
            begin failures++; $display("FAIL basic_rsp got gcd=%0d iter=%0d id=%0d err=%b exp 4/3/0/0", bus.rsp_gcd, bus.rsp_iter, bus.rsp_id, bus.rsp_err); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy_done got=%b exp=1", bus.busy); end
        ack();
        checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL basic_after_ack got valid=%b busy=%b exp 0/0", bus.rsp_valid, bus.busy); end
        checks++; if (bus.rsp_gcd !== 8'd4) begin failures++; $display("FAIL basic_hold got=%0d exp=4", bus.rsp_gcd); end
    endtask

    task automatic test_zero();
        logic [3:0] rdy;
        int n;
        logic [7:0] av [3] = '{8'd0, 8'd0, 8'd7};
        logic [7:0] bv [3] = '{8'd0, 8'd9, 8'd0};
        logic [7:0] ev [3] = '{8'd0, 8'd9, 8'd7};
        for (int i = 0; i < 3; i++) begin
            do_op(1, av[i], bv[i], rdy, n);
            checks++; if (n !== 1) begin failures++; $display("FAIL zero_latency case=%0d got=%0d exp=1", i, n); end
            checks++; if (bus.rsp_gcd !== ev[i] || bus.rsp_iter !== 10'd0 || bus.rsp_id !== 2'd1 || bus.rsp_err !== 1'b0)
                begin failures++; $display("FAIL zero_rsp case=%0d got gcd=%0d iter=%0d id=%0d err=%b exp %0d/0/1/0", i, bus.rsp_gcd, bus.rsp_iter, bus.rsp_id, bus.rsp_err, ev[i]); end
            ack();
        end
    endtask

    task automatic test_worst();
        logic [3:0] rdy;
        int n;
        do_op(2, 8'd255, 8'd1, rdy, n);
        checks++; if (n !== 255) begin failures++; $display("FAIL worst_latency got=%0d exp=255", n); end
        checks++; if (bus.rsp_gcd !== 8'd1 || bus.rsp_iter !== 10'd254 || bus.rsp_id !== 2'd2 || bus.rsp_err !== 1'b0)
            begin failures++; $display("FAIL worst_rsp got gcd=%0d iter=%0d id=%0d err=%b exp 1/254/2/0", bus.rsp_gcd, bus.rsp_iter, bus.rsp_id, bus.rsp_err); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_gcd !== 8'd1 || bus.rsp_iter !== 10'd254 || bus.rsp_id !== 2'd2)
                begin failures++; $display("FAIL worst_hold cyc=%0d got valid=%b gcd=%0d iter=%0d id=%0d", c, bus.rsp_valid, bus.rsp_gcd, bus.rsp_iter, bus.rsp_id); end
        end
        ack();
    endtask

    task automatic test_maxiter();
        int n;
        bus2.req_valid = 4'b0001;
        bus2.req_a[7:0] = 8'd200;
        bus2.req_b[7:0] = 8'd3;
        @(posedge clk);
        @(negedge clk);
        bus2.req_valid = 4'b0000;
        n = 0;
        while (!bus2.rsp_valid && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        checks++; if (n !== 11) begin failures++; $display("FAIL maxiter_latency got=%0d exp=11", n); end
        checks++; if (bus2.rsp_err !== 1'b1 || bus2.rsp_gcd !== 8'd0 || bus2.rsp_iter !== 4'd10)
            begin failures++; $display("FAIL maxiter_rsp got err=%b gcd=%0d iter=%0d exp 1/0/10", bus2.rsp_err, bus2.rsp_gcd, bus2.rsp_iter); end
        bus2.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus2.rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_rdy [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [1:0] exp_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [7:0] exp_gcd [5] = '{8'd4, 8'd3, 8'd7, 8'd8, 8'd4};
        int n;
        bus.req_a = {8'd16, 8'd35, 8'd9, 8'd12};
        bus.req_b = {8'd24, 8'd14, 8'd6, 8'd8};
        bus.req_valid = 4'b1111;
        // Pointer sits at 2 after test_worst; reset it so the order starts at 0.
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int g = 0; g < 5; g++) begin
            #1;
            checks++; if (bus.req_ready !== exp_rdy[g]) begin failures++; $display("FAIL rr_grant g=%0d got=%b exp=%b", g, bus.req_ready, exp_rdy[g]); end
            @(posedge clk);
            @(negedge clk);
            if (g == 4) bus.req_valid = 4'b0000;
            n = 0;
            while (!bus.rsp_valid && n < 100) begin
                @(posedge clk);
                @(negedge clk);
                n++;
            end
            checks++; if (bus.rsp_id !== exp_id[g] || bus.rsp_gcd !== exp_gcd[g] || bus.rsp_err !== 1'b0)
                begin failures++; $display("FAIL rr_rsp g=%0d got id=%0d gcd=%0d err=%b exp %0d/%0d/0", g, bus.rsp_id, bus.rsp_gcd, bus.rsp_err, exp_id[g], exp_gcd[g]); end
            ack();
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        logic [3:0] rdy;
        int n;
        bus.req_valid = 4'b0100;
        bus.req_a[23:16] = 8'd100;
        bus.req_b[23:16] = 8'd75;
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin failures++; $display("FAIL mid_grant got=%b exp=0100", bus.req_ready); end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mid_idle got busy=%b exp=0", bus.busy); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL mid_no_rsp got valid_cycles=%0d exp=0", seen); end
        bus.req_valid = 4'b1010;
        bus.req_a[15:8] = 8'd50;
        bus.req_b[15:8] = 8'd20;
        bus.req_a[31:24] = 8'd50;
        bus.req_b[31:24] = 8'd20;
        do_op(0, 8'd21, 8'd14, rdy, n);
        bus.req_valid = 4'b0000;
        checks++; if (rdy !== 4'b0001) begin failures++; $display("FAIL mid_next_grant got=%b exp=0001", rdy); end
        checks++; if (bus.rsp_id !== 2'd0 || bus.rsp_gcd !== 8'd7) begin failures++; $display("FAIL mid_next_rsp got id=%0d gcd=%0d exp 0/7", bus.rsp_id, bus.rsp_gcd); end
        ack();
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b0;
        bus2.req_valid = '0;
        bus2.req_a = '0;
        bus2.req_b = '0;
        bus2.rsp_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_zero();
        test_worst();
        test_maxiter();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
